// File: rtl/prng_share_scheduler_pkg.sv
// rtl/prng_share_scheduler_pkg.sv - shared state/tag encodings and width helper for the PRNG share scheduler
package prng_share_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEED   = 2'd1,
        ST_WARMUP = 2'd2,
        ST_RUN    = 2'd3
    } sched_state_e;

    typedef enum logic {
        TAG_CH1 = 1'b0,
        TAG_CH2 = 1'b1
    } chan_tag_e;

    // Width of a counter that walks 0 .. n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prng_share_scheduler_if.sv
// rtl/prng_share_scheduler_if.sv - seed, PRNG-core and channel handshake bundle of the PRNG share scheduler
interface prng_share_scheduler_if #(
    parameter int RND_W = 32
) ();
    logic             seed_valid;
    logic             seed_ready;
    logic             prng_load;
    logic             prng_en;
    logic [RND_W-1:0] prng_dout;
    logic             reseed_req;
    logic             rnd1_valid;
    logic             rnd1_ready;
    logic [RND_W-1:0] rnd1_data;
    logic             rnd2_valid;
    logic             rnd2_ready;
    logic [RND_W-1:0] rnd2_data;
    logic             prng_rdy;

    // Scheduler side.
    modport master (
        input  seed_valid, prng_dout, reseed_req, rnd1_ready, rnd2_ready,
        output seed_ready, prng_load, prng_en, rnd1_valid, rnd1_data,
               rnd2_valid, rnd2_data, prng_rdy
    );

    // PRNG core, seed source and randomness consumers.
    modport slave (
        output seed_valid, prng_dout, reseed_req, rnd1_ready, rnd2_ready,
        input  seed_ready, prng_load, prng_en, rnd1_valid, rnd1_data,
               rnd2_valid, rnd2_data, prng_rdy
    );
endinterface

// File: rtl/prng_share_scheduler_rnd_word_buffer.sv
// rtl/prng_share_scheduler_rnd_word_buffer.sv - one-word valid/ready holder with a capture port
module rnd_word_buffer #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cap_i,
    input  logic [W-1:0] cap_data_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);
    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    // A capture wins over a same-cycle take so a refill is never lost.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        if (cap_i) begin
            valid_d = 1'b1;
            data_d  = cap_data_i;
        end
    end

    // Buffer registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
endmodule

// File: rtl/prng_share_scheduler.sv
// rtl/prng_share_scheduler.sv - PRNG life-cycle sequencer and round-robin word issue to two randomness channels
module prng_share_scheduler
    import prng_share_scheduler_pkg::*;
#(
    parameter int RND_W         = 32,
    parameter int WARMUP_CYCLES = 8,
    parameter int RESEED_PERIOD = 1024
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    prng_share_scheduler_if.master     bus
);
    localparam int unsigned WARM_W = cnt_width(WARMUP_CYCLES);
    localparam int unsigned ISS_W  = cnt_width(RESEED_PERIOD);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYCLES - 1);
    localparam logic [ISS_W-1:0]  ISS_LAST  = ISS_W'(RESEED_PERIOD - 1);

    sched_state_e      state_q, state_d;
    logic [WARM_W-1:0] warm_cnt_q, warm_cnt_d;
    logic [ISS_W-1:0]  issue_cnt_q, issue_cnt_d;
    logic              inflight_q, inflight_d;
    chan_tag_e         tag_q, tag_d;
    logic              rr_q, rr_d;

    logic              needy1, needy2, issue;
    chan_tag_e         grant;

    // Life-cycle FSM and issue arbitration; a channel whose word is already
    // in flight is not needy, so it never gets a second step queued behind it.
    always_comb begin
        state_d     = state_q;
        warm_cnt_d  = warm_cnt_q;
        issue_cnt_d = issue_cnt_q;
        rr_d        = rr_q;
        issue       = 1'b0;
        grant       = TAG_CH1;
        needy1      = (~bus.rnd1_valid | bus.rnd1_ready) & ~(inflight_q & (tag_q == TAG_CH1));
        needy2      = (~bus.rnd2_valid | bus.rnd2_ready) & ~(inflight_q & (tag_q == TAG_CH2));
        case (state_q)
            ST_IDLE: begin
                state_d = ST_SEED;
            end
            ST_SEED: begin
                if (bus.seed_valid) begin
                    state_d    = ST_WARMUP;
                    warm_cnt_d = '0;
                end
            end
            ST_WARMUP: begin
                if (warm_cnt_q == WARM_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    warm_cnt_d = warm_cnt_q + WARM_W'(1);
                end
            end
            ST_RUN: begin
                if (bus.reseed_req) begin
                    state_d     = ST_SEED;
                    issue_cnt_d = '0;
                end else if (needy1 || needy2) begin
                    issue = 1'b1;
                    if (needy1 && needy2) begin
                        grant = rr_q ? TAG_CH2 : TAG_CH1;
                        rr_d  = ~rr_q;
                    end else begin
                        grant = needy1 ? TAG_CH1 : TAG_CH2;
                    end
                    if ((RESEED_PERIOD != 0) && (issue_cnt_q == ISS_LAST)) begin
                        state_d     = ST_SEED;
                        issue_cnt_d = '0;
                    end else begin
                        issue_cnt_d = issue_cnt_q + ISS_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        inflight_d = issue;
        tag_d      = issue ? grant : tag_q;
    end

    // Scheduler state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            warm_cnt_q  <= '0;
            issue_cnt_q <= '0;
            inflight_q  <= 1'b0;
            tag_q       <= TAG_CH1;
            rr_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            warm_cnt_q  <= warm_cnt_d;
            issue_cnt_q <= issue_cnt_d;
            inflight_q  <= inflight_d;
            tag_q       <= tag_d;
            rr_q        <= rr_d;
        end
    end

    assign bus.seed_ready = (state_q == ST_SEED);
    assign bus.prng_load  = bus.seed_valid & (state_q == ST_SEED);
    assign bus.prng_en    = issue | (state_q == ST_WARMUP);
    assign bus.prng_rdy   = (state_q == ST_RUN);

    // The word issued last cycle lands in its channel regardless of state,
    // so a step issued just before a reseed is still delivered.
    rnd_word_buffer #(.W(RND_W)) u_buf1 (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cap_i      (inflight_q & (tag_q == TAG_CH1)),
        .cap_data_i (bus.prng_dout),
        .ready_i    (bus.rnd1_ready),
        .valid_o    (bus.rnd1_valid),
        .data_o     (bus.rnd1_data)
    );

    rnd_word_buffer #(.W(RND_W)) u_buf2 (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cap_i      (inflight_q & (tag_q == TAG_CH2)),
        .cap_data_i (bus.prng_dout),
        .ready_i    (bus.rnd2_ready),
        .valid_o    (bus.rnd2_valid),
        .data_o     (bus.rnd2_data)
    );
endmodule

// File: tb/tb_prng_share_scheduler.sv
// tb/tb_prng_share_scheduler.sv - randomized model-checked bench for prng_share_scheduler
module tb_prng_share_scheduler;
    localparam int RND_W  = 32;
    localparam int WARM   = 8;
    localparam int PERIOD = 8;
    localparam int NCYC   = 3000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prng_share_scheduler_if #(.RND_W(RND_W)) bus ();

    prng_share_scheduler #(
        .RND_W         (RND_W),
        .WARMUP_CYCLES (WARM),
        .RESEED_PERIOD (PERIOD)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: life-cycle phase with countdowns, a queue of
    // outstanding PRNG steps (channel per step), and the two delivery slots.
    localparam int P_IDLE = 0, P_SEED = 1, P_WARM = 2, P_RUN = 3;
    int               m_phase;
    int               m_warm_left;
    int               m_issues_left;
    bit               m_full [2];
    logic [RND_W-1:0] m_word [2];
    int               m_flight [$];
    int               m_prefer;

    bit e_issue, e_tie;
    int e_grant;
    int run_cycles = 0;
    int words_seen = 0;

    task automatic model_reset();
        m_phase       = P_IDLE;
        m_warm_left   = 0;
        m_issues_left = PERIOD;
        m_full[0]     = 1'b0;
        m_full[1]     = 1'b0;
        m_word[0]     = '0;
        m_word[1]     = '0;
        m_flight.delete();
        m_prefer      = 0;
    endtask

    task automatic model_decide();
        bit hungry [2];
        bit rdy [2];
        rdy[0] = bus.rnd1_ready;
        rdy[1] = bus.rnd2_ready;
        for (int c = 0; c < 2; c++) begin
            hungry[c] = (!m_full[c] || rdy[c]) && !(m_flight.size() > 0 && m_flight[0] == c);
        end
        e_issue = (m_phase == P_RUN) && !bus.reseed_req && (hungry[0] || hungry[1]);
        e_tie   = hungry[0] && hungry[1];
        e_grant = e_tie ? m_prefer : (hungry[0] ? 0 : 1);
    endtask

    task automatic model_step();
        if (m_full[0] && bus.rnd1_ready) m_full[0] = 1'b0;
        if (m_full[1] && bus.rnd2_ready) m_full[1] = 1'b0;
        if (m_flight.size() > 0) begin
            int c;
            c = m_flight.pop_front();
            m_full[c] = 1'b1;
            m_word[c] = bus.prng_dout;
        end
        if (e_issue) begin
            m_flight.push_back(e_grant);
            if (e_tie) m_prefer = 1 - m_prefer;
        end
        case (m_phase)
            P_IDLE: begin
                m_phase       = P_SEED;
                m_issues_left = PERIOD;
            end
            P_SEED: if (bus.seed_valid) begin
                m_phase     = P_WARM;
                m_warm_left = WARM;
            end
            P_WARM: begin
                m_warm_left--;
                if (m_warm_left == 0) m_phase = P_RUN;
            end
            default: begin
                if (bus.reseed_req) begin
                    m_phase       = P_SEED;
                    m_issues_left = PERIOD;
                end else if (e_issue) begin
                    m_issues_left--;
                    if (m_issues_left == 0) begin
                        m_phase       = P_SEED;
                        m_issues_left = PERIOD;
                    end
                end
            end
        endcase
    endtask

    task automatic check_outputs();
        check("seed_ready", bus.seed_ready, m_phase == P_SEED);
        check("prng_load",  bus.prng_load,  (m_phase == P_SEED) && bus.seed_valid);
        check("prng_en",    bus.prng_en,    e_issue || (m_phase == P_WARM));
        check("prng_rdy",   bus.prng_rdy,   m_phase == P_RUN);
        check("rnd1_valid", bus.rnd1_valid, m_full[0]);
        check("rnd2_valid", bus.rnd2_valid, m_full[1]);
        if (m_full[0]) check("rnd1_data", bus.rnd1_data, m_word[0]);
        if (m_full[1]) check("rnd2_data", bus.rnd2_data, m_word[1]);
    endtask

    initial begin
        int  mode;
        bit  rst_done;
        bus.seed_valid = 1'b1;
        bus.reseed_req = 1'b0;
        bus.rnd1_ready = 1'b1;
        bus.rnd2_ready = 1'b1;
        bus.prng_dout  = '0;
        model_reset();

        // Outputs while held in reset, even with a seed offered.
        repeat (2) @(posedge clk);
        #1;
        check("rst_seed_ready", bus.seed_ready, 1'b0);
        check("rst_prng_load",  bus.prng_load,  1'b0);
        check("rst_prng_en",    bus.prng_en,    1'b0);
        check("rst_prng_rdy",   bus.prng_rdy,   1'b0);
        check("rst_rnd1_valid", bus.rnd1_valid, 1'b0);
        check("rst_rnd2_valid", bus.rnd2_valid, 1'b0);
        check("rst_rnd1_data",  bus.rnd1_data,  '0);
        check("rst_rnd2_data",  bus.rnd2_data,  '0);
        rst = 1'b0;
        rst_done = 1'b0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            mode = (cyc / 60) % 5;
            if (cyc % 60 == 0) rst_done = 1'b0;
            bus.prng_dout  = $urandom;
            bus.seed_valid = (mode == 1) ? 1'b1 : ($urandom_range(0, 3) == 0);
            bus.reseed_req = (mode == 3) ? ($urandom_range(0, 7) == 0) : 1'b0;
            case (mode)
                1:       begin bus.rnd1_ready = 1'b1; bus.rnd2_ready = 1'b1; end
                2:       begin bus.rnd1_ready = 1'b1; bus.rnd2_ready = 1'b0; end
                4:       begin bus.rnd1_ready = 1'b0; bus.rnd2_ready = 1'b0; end
                default: begin bus.rnd1_ready = 1'($urandom); bus.rnd2_ready = 1'($urandom); end
            endcase
            #1;
            model_decide();
            check_outputs();
            if (m_phase == P_RUN) run_cycles++;
            if (bus.rnd1_valid && bus.rnd1_ready) words_seen++;
            if (bus.rnd2_valid && bus.rnd2_ready) words_seen++;

            if (mode == 4 && !rst_done && m_phase == P_RUN && m_full[0] && m_full[1]) begin
                // Asynchronous reset in the middle of a cycle with both slots full.
                #2;
                rst = 1'b1;
                #1;
                check("arst_rnd1_valid", bus.rnd1_valid, 1'b0);
                check("arst_rnd2_valid", bus.rnd2_valid, 1'b0);
                check("arst_prng_en",    bus.prng_en,    1'b0);
                check("arst_prng_rdy",   bus.prng_rdy,   1'b0);
                check("arst_seed_ready", bus.seed_ready, 1'b0);
                model_reset();
                rst_done = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
            end else begin
                @(posedge clk);
                model_step();
                #1;
            end
        end

        check("run_reached", run_cycles > 0, 1'b1);
        check("words_moved", words_seen > 0, 1'b1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
